inst_ram_loader: RTL

Parametrised instruction-RAM boot loader sitting between a program source and the CPU's instruction-RAM write port. It accepts a valid/ready word stream, writes words to consecutive addresses from `PC_INITIAL`, holds the CPU in reset and debug mode while loading, then releases the CPU. It replaces hand-sequenced per-word write scripts with a reusable, length-agnostic loader that has overflow detection and an optional readback check.

---
 rtl/inst_ram_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/inst_ram_loader.sv
// inst_ram_loader: instruction-RAM boot loader.
// Accepts a valid/ready word stream and writes it to consecutive RAM
// addresses starting at PC_INITIAL. While loading, the CPU is held in reset
// and debug mode. It is released once the program has been written.
// Optional readback verification is built when the macro
// INST_RAM_LOADER_VERIFY_EN is defined. That build adds a VERIFY state,
// a read port and a readback checksum.

module inst_ram_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_INITIAL = ADDR_WIDTH'(32'hbfc00000),
  parameter int                    ADDR_STEP  = 4,
  parameter int                    MAX_WORDS  = 256,
  localparam int                   CNT_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  inst_ram_write_enable,
  output logic [DATA_WIDTH-1:0] inst_ram_write_data,
  output logic [ADDR_WIDTH-1:0] inst_ram_write_address,
  output logic [ADDR_WIDTH-1:0] inst_ram_read_address,
  input  logic [DATA_WIDTH-1:0] inst_ram_read_data,
  output logic                  cpu_reset,
  output logic                  debug,
  output logic [CNT_W-1:0]      word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0]      ONE_CNT = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic                    beat;        // word accepted on this edge
  logic                    restart;     // start honoured in this state
  logic                    at_capacity; // this beat fills the last slot
  logic [CNT_W-1:0]        count_inc;

  logic [CNT_W-1:0]        count_reg;
  logic [ADDR_WIDTH-1:0]   next_addr_reg;  // address the next beat goes to
  logic [DATA_WIDTH-1:0]   checksum_reg;   // XOR of every accepted word
  logic                    we_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [ADDR_WIDTH-1:0]   waddr_reg;
  logic                    cpu_reset_reg;
  logic                    run_arm_reg;    // RUN has been stable for a cycle

  // Ready depends only on the state register, so a beat is just valid in LOAD.
  assign beat        = (state_reg == S_LOAD) && load_valid;
  assign restart     = start && ((state_reg == S_IDLE) || (state_reg == S_RUN) ||
                                 (state_reg == S_ERROR));
  assign count_inc   = count_reg + ONE_CNT;
  assign at_capacity = (count_inc == MAX_CNT);

`ifdef INST_RAM_LOADER_VERIFY_EN
  localparam int VW = CNT_W + 1;

  logic [VW-1:0]         vcnt_reg;   // cycles spent in VERIFY so far
  logic [ADDR_WIDTH-1:0] raddr_reg;
  logic [DATA_WIDTH-1:0] rb_sum_reg; // XOR of data read back
  logic [VW-1:0]         wc_ext;
  logic                  verify_last;
  logic                  verify_ok;

  assign wc_ext      = {1'b0, count_reg};
  // Reads go out in cycles 0..wc-1 and data lands in cycles 1..wc.
  // The checksums are compared in cycle wc+1.
  assign verify_last = (vcnt_reg == wc_ext + VW'(1));
  assign verify_ok   = (rb_sum_reg == checksum_reg);
  assign inst_ram_read_address = raddr_reg;

  // Readback pipeline: one read per cycle, and data XORed in one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcnt_reg   <= '0;
      raddr_reg  <= PC_INITIAL;
      rb_sum_reg <= '0;
    end else if (state_reg != S_VERIFY) begin
      vcnt_reg   <= '0;
      raddr_reg  <= PC_INITIAL;
      rb_sum_reg <= '0;
    end else begin
      vcnt_reg <= vcnt_reg + VW'(1);
      if (vcnt_reg + VW'(1) < wc_ext) begin
        raddr_reg <= raddr_reg + STEP;
      end
      if ((vcnt_reg != '0) && (vcnt_reg <= wc_ext)) begin
        rb_sum_reg <= rb_sum_reg ^ inst_ram_read_data;
      end
    end
  end
`else
  // Without verification the read port is parked and its data is ignored.
  logic unused_readback;
  assign unused_readback       = ^{inst_ram_read_data, checksum_reg};
  assign inst_ram_read_address = PC_INITIAL;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (load_last) begin
`ifdef INST_RAM_LOADER_VERIFY_EN
            state_next = S_VERIFY;
`else
            state_next = S_RUN;
`endif
          end else if (at_capacity) begin
            state_next = S_ERROR;
          end
        end
      end
      S_VERIFY: begin
`ifdef INST_RAM_LOADER_VERIFY_EN
        if (verify_last) begin
          state_next = verify_ok ? S_RUN : S_ERROR;
        end
`else
        state_next = S_IDLE;
`endif
      end
      S_RUN, S_ERROR: begin
        if (start) begin
          state_next = S_LOAD;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Write port, word counter, next address and load checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      waddr_reg     <= PC_INITIAL;
      count_reg     <= '0;
      next_addr_reg <= PC_INITIAL;
      checksum_reg  <= '0;
    end else begin
      we_reg <= beat;
      if (restart) begin
        count_reg     <= '0;
        next_addr_reg <= PC_INITIAL;
        checksum_reg  <= '0;
      end
      if (beat) begin
        wdata_reg     <= load_data;
        waddr_reg     <= next_addr_reg;
        next_addr_reg <= next_addr_reg + STEP;
        count_reg     <= count_inc;
        checksum_reg  <= checksum_reg ^ load_data;
      end
    end
  end

  // The CPU hold is released only after RUN has lasted a full cycle. That
  // keeps it clear of the final write strobe. A restart re-asserts it at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_arm_reg   <= 1'b0;
      cpu_reset_reg <= 1'b1;
    end else begin
      run_arm_reg   <= (state_reg == S_RUN) && !start;
      cpu_reset_reg <= !(run_arm_reg && (state_reg == S_RUN) && !start);
    end
  end

  assign load_ready             = (state_reg == S_LOAD);
  assign busy                   = (state_reg == S_LOAD) || (state_reg == S_VERIFY);
  assign debug                  = busy;
  assign done                   = (state_reg == S_RUN);
  assign error                  = (state_reg == S_ERROR);
  assign cpu_reset              = cpu_reset_reg;
  assign word_count             = count_reg;
  assign inst_ram_write_enable  = we_reg;
  assign inst_ram_write_data    = wdata_reg;
  assign inst_ram_write_address = waddr_reg;

endmodule
